// File: rtl/qam_symbol_mapper.sv
// Serial-bit to QPSK/16QAM symbol mapper on the system clock.
// Bit strobes come from rising edges of the divided bit clock; I/Q are Gray-coded and held between symbols.
module qam_symbol_mapper #(
    parameter int AMP   = 32,
    parameter int OUT_W = 8
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    mod_type,
    input  logic                    clk_bitstream,
    input  logic                    bit_in,
    output logic                    bit_req,
    output logic signed [OUT_W-1:0] i_out,
    output logic signed [OUT_W-1:0] q_out,
    output logic                    sym_valid,
    output logic [15:0]             sym_cnt
);

    typedef enum logic {
        MODE_QPSK  = 1'b0,
        MODE_16QAM = 1'b1
    } mode_e;

    localparam logic signed [OUT_W-1:0] LVL_N3 = OUT_W'(-3 * AMP);
    localparam logic signed [OUT_W-1:0] LVL_N1 = OUT_W'(-AMP);
    localparam logic signed [OUT_W-1:0] LVL_P1 = OUT_W'(AMP);
    localparam logic signed [OUT_W-1:0] LVL_P3 = OUT_W'(3 * AMP);

    logic        bs_d;
    logic [1:0]  bit_cnt;
    mode_e       mt_lat;
    // The current bit completes the word, so only the three earlier bits are stored.
    logic [2:0]  shreg;

    logic        bit_stb;
    logic        mode_abort;
    logic [1:0]  cur_cnt;
    logic        start_sym;
    mode_e       sym_mode;
    logic [1:0]  last_idx;
    logic        sym_done;
    logic [3:0]  word;
    logic signed [OUT_W-1:0] i_next;
    logic signed [OUT_W-1:0] q_next;

    function automatic logic signed [OUT_W-1:0] gray_level(input logic [1:0] g);
        case (g)
            2'b00:   return LVL_N3;
            2'b01:   return LVL_N1;
            2'b11:   return LVL_P1;
            default: return LVL_P3;
        endcase
    endfunction

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        bit_stb    = clk_bitstream & ~bs_d & en;
        bit_req    = bit_stb;
        mode_abort = (mode_e'(mod_type) != mt_lat) && (bit_cnt != 2'd0);
        cur_cnt    = mode_abort ? 2'd0 : bit_cnt;
        start_sym  = (cur_cnt == 2'd0);
        sym_mode   = start_sym ? mode_e'(mod_type) : mt_lat;
        last_idx   = (sym_mode == MODE_16QAM) ? 2'd3 : 2'd1;
        sym_done   = bit_stb && (cur_cnt == last_idx);
        word       = {shreg, bit_in};
        i_next     = '0;
        q_next     = '0;
        if (sym_mode == MODE_16QAM) begin
            i_next = gray_level(word[3:2]);
            q_next = gray_level(word[1:0]);
        end else begin
            i_next = word[1] ? LVL_P3 : LVL_N3;
            q_next = word[0] ? LVL_P3 : LVL_N3;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            bs_d      <= 1'b1;
            bit_cnt   <= 2'd0;
            mt_lat    <= MODE_QPSK;
            shreg     <= 3'd0;
            i_out     <= '0;
            q_out     <= '0;
            sym_valid <= 1'b0;
            sym_cnt   <= 16'd0;
        end else begin
            bs_d      <= clk_bitstream;
            sym_valid <= 1'b0;
            if (!en) begin
                bit_cnt <= 2'd0;
            end else if (bit_stb) begin
                shreg <= word[2:0];
                if (start_sym) begin
                    mt_lat <= mode_e'(mod_type);
                end
                if (sym_done) begin
                    bit_cnt   <= 2'd0;
                    i_out     <= i_next;
                    q_out     <= q_next;
                    sym_valid <= 1'b1;
                    sym_cnt   <= sym_cnt + 16'd1;
                end else begin
                    bit_cnt <= cur_cnt + 2'd1;
                end
            end else if (mode_abort) begin
                bit_cnt <= 2'd0;
            end
        end
    end

endmodule
